logits_argmax_reader: RTL and testbench

- Consumer end of the final dense layer's result interface.
- Launches the 128-to-10 layer, waits for its done level, then reads the NUM_CLASSES signed 64-bit logits through the layer's read_addr/read_data port.
- Computes the argmax and presents class index plus winning score to the SoC (CPU MMIO / secure result register).
- Sits between the last dense layer and the SoC result path.

---
 rtl/logits_argmax_reader.sv | 214 +++++++++++++++++++++
 tb/tb_logits_argmax_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logits_argmax_reader.sv
// logits_argmax_reader: launches the final dense layer, waits for its done
// level, reads NUM_CLASSES signed logits over read_addr/read_data and
// reports the argmax index and winning score to the SoC result path.
// Build option: define LAYER_TIMEOUT_EN to bound the wait for layer_done
// (TIMEOUT_CYCLES) and flag expiry on err; otherwise err is constant 0.
module logits_argmax_reader #(
    parameter int unsigned NUM_CLASSES  = 10,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_STRIDE  = 16,
    parameter int unsigned READ_LATENCY = 1
`ifdef LAYER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              layer_start,
    input  logic              layer_done,
    output logic [31:0]       rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              result_valid,
    output logic              done_pulse,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              err
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned ADDR_W = 32;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_LAYER = 3'd2,
        ISSUE      = 3'd3,
        WAIT_RD    = 3'd4,
        COMPARE    = 3'd5,
        FINISH     = 3'd6
    } state_t;

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         k, k_nxt;
    logic [LAT_W-1:0]         lat_cnt, lat_cnt_nxt;
    logic signed [DATA_W-1:0] sample, sample_nxt;
    logic signed [DATA_W-1:0] best_score, best_score_nxt;
    logic [IDX_W-1:0]         best_idx, best_idx_nxt;

    logic                     layer_start_nxt;
    logic [ADDR_W-1:0]        rd_addr_nxt;
    logic                     busy_nxt;
    logic                     result_valid_nxt;
    logic                     done_pulse_nxt;
    logic [3:0]               class_idx_nxt;
    logic [DATA_W-1:0]        class_score_nxt;
    logic                     err_nxt;

`ifdef LAYER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt, to_cnt_nxt;
`endif

    // State, datapath and output registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            k            <= '0;
            lat_cnt      <= '0;
            sample       <= '0;
            best_score   <= '0;
            best_idx     <= '0;
            layer_start  <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            done_pulse   <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
            err          <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            lat_cnt      <= lat_cnt_nxt;
            sample       <= sample_nxt;
            best_score   <= best_score_nxt;
            best_idx     <= best_idx_nxt;
            layer_start  <= layer_start_nxt;
            rd_addr      <= rd_addr_nxt;
            busy         <= busy_nxt;
            result_valid <= result_valid_nxt;
            done_pulse   <= done_pulse_nxt;
            class_idx    <= class_idx_nxt;
            class_score  <= class_score_nxt;
            err          <= err_nxt;
`ifdef LAYER_TIMEOUT_EN
            to_cnt       <= to_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds
    always_comb begin
        state_nxt        = state;
        k_nxt            = k;
        lat_cnt_nxt      = lat_cnt;
        sample_nxt       = sample;
        best_score_nxt   = best_score;
        best_idx_nxt     = best_idx;
        layer_start_nxt  = 1'b0;
        rd_addr_nxt      = rd_addr;
        busy_nxt         = busy;
        result_valid_nxt = result_valid;
        done_pulse_nxt   = 1'b0;
        class_idx_nxt    = class_idx;
        class_score_nxt  = class_score;
`ifdef LAYER_TIMEOUT_EN
        err_nxt          = err;
        to_cnt_nxt       = to_cnt;
`else
        err_nxt          = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    busy_nxt         = 1'b1;
                    result_valid_nxt = 1'b0;
                    err_nxt          = 1'b0;
                    k_nxt            = '0;
                    // A finished layer ignores start, so just re-read its cached logits
                    if (layer_done) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt       = LAUNCH;
                        layer_start_nxt = 1'b1;
                    end
                end
            end

            LAUNCH: begin
                state_nxt = WAIT_LAYER;
`ifdef LAYER_TIMEOUT_EN
                to_cnt_nxt = '0;
`endif
            end

            WAIT_LAYER: begin
                if (layer_done) begin
                    state_nxt = ISSUE;
                end
`ifdef LAYER_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    err_nxt        = 1'b1;
                    busy_nxt       = 1'b0;
                    done_pulse_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 32'd1;
                end
`endif
            end

            ISSUE: begin
                rd_addr_nxt = ADDR_W'(k) * ADDR_W'(ADDR_STRIDE);
                lat_cnt_nxt = LAT_W'(READ_LATENCY);
                state_nxt   = WAIT_RD;
            end

            WAIT_RD: begin
                if (lat_cnt == '0) begin
                    sample_nxt = rd_data;
                    state_nxt  = COMPARE;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end

            COMPARE: begin
                // Strict greater-than keeps the lowest index on ties
                if ((k == '0) || (sample > best_score)) begin
                    best_score_nxt = sample;
                    best_idx_nxt   = k;
                end
                if (k == LAST_K) begin
                    state_nxt = FINISH;
                end else begin
                    k_nxt     = k + IDX_W'(1);
                    state_nxt = ISSUE;
                end
            end

            FINISH: begin
                class_idx_nxt    = best_idx;
                class_score_nxt  = best_score;
                result_valid_nxt = 1'b1;
                done_pulse_nxt   = 1'b1;
                busy_nxt         = 1'b0;
                state_nxt        = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_logits_argmax_reader.sv
// Directed bench for logits_argmax_reader with a registered BRAM model for
// the dense layer read port and a negedge monitor for pulses and addresses.
`timescale 1ns/1ps
module tb_logits_argmax_reader;

    localparam int unsigned NUM_CLASSES  = 10;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned ADDR_STRIDE  = 16;
    localparam int unsigned READ_LATENCY = 1;
    localparam int LAT_CYC = 1 + NUM_CLASSES * (READ_LATENCY + 3) + 1;

    typedef logic [63:0] vec_t [NUM_CLASSES];

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              layer_done = 1'b0;
    logic              layer_start;
    logic [31:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              result_valid;
    logic              done_pulse;
    logic [3:0]        class_idx;
    logic [DATA_W-1:0] class_score;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t mem;
    vec_t va = '{64'd5, -64'sd3, 64'd12, 64'd0, 64'd7, 64'd12, -64'sd100, 64'd1, 64'd2, 64'd3};
    vec_t vb = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
    vec_t vc = '{-64'sd3, 64'h8000_0000_0000_0000, -64'sd10, -64'sd1000, -64'sd7,
                 -64'sd3, -64'sd4, -64'sd50, -64'sd3, -64'sd2};
    vec_t ve = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd20, 64'd9};
    vec_t vf = '{64'd7, 64'd1, 64'd7, 64'd2, 64'd9, 64'd9, 64'd3, 64'd9, 64'd0, 64'd8};
    vec_t vg = '{-64'sd7, 64'd3, 64'd3, -64'sd1, 64'd2, 64'd11, 64'd11, 64'd0, -64'sd5, 64'd4};

    always #5 clk = ~clk;

    logits_argmax_reader #(
        .NUM_CLASSES  (NUM_CLASSES),
        .DATA_W       (DATA_W),
        .ADDR_STRIDE  (ADDR_STRIDE),
        .READ_LATENCY (READ_LATENCY)
`ifdef LAYER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .layer_start  (layer_start),
        .layer_done   (layer_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .result_valid (result_valid),
        .done_pulse   (done_pulse),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .err          (err)
    );

    // Dense-layer result BRAM: READ_LATENCY registered stages from rd_addr
    function automatic logic [63:0] bram_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = a / ADDR_STRIDE;
        if (idx < NUM_CLASSES) return mem[idx[3:0]];
        return 64'd0;
    endfunction

    logic [63:0] pipe [READ_LATENCY];
    always @(posedge clk) begin
        pipe[0] <= bram_word(rd_addr);
        for (int i = 1; i < int'(READ_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[READ_LATENCY-1];

    // Monitor: counts pulse cycles and logs every change of rd_addr
    int          ls_cnt = 0;
    int          dp_cnt = 0;
    logic [31:0] addr_log [$];
    logic [31:0] prev_addr = 32'd0;
    logic        mon_clr = 1'b0;
    always @(negedge clk) begin
        if (mon_clr) begin
            ls_cnt = 0;
            dp_cnt = 0;
            addr_log.delete();
        end else begin
            if (layer_start) ls_cnt++;
            if (done_pulse) dp_cnt++;
            if (rd_addr != prev_addr) addr_log.push_back(rd_addr);
        end
        prev_addr = rd_addr;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    // Returns in cycle 1 (cycle 0 is the one with start high)
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 1;
        while (cyc <= limit) begin
            if (done_pulse) begin
                seen = 1'b1;
                return;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic check_addr(input string tag, input int first_k);
        int n_exp;
        n_exp = int'(NUM_CLASSES) - first_k;
        check({tag, "_n"}, 64'(addr_log.size()), 64'(n_exp));
        for (int i = 0; i < addr_log.size() && i < n_exp; i++)
            check({tag, "_a"}, 64'(addr_log[i]), 64'((first_k + i) * int'(ADDR_STRIDE)));
    endtask

    task automatic check_zero(input string p);
        check({p, "_layer_start"}, 64'(layer_start), 64'd0);
        check({p, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_result_valid"}, 64'(result_valid), 64'd0);
        check({p, "_done_pulse"}, 64'(done_pulse), 64'd0);
        check({p, "_class_idx"}, 64'(class_idx), 64'd0);
        check({p, "_class_score"}, class_score, 64'd0);
        check({p, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int cyc;

        // Reset values
        resetn = 1'b0;
        repeat (3) tick();
        check_zero("rst");
        resetn = 1'b1;
        tick();

        // A: layer not done -> one launch, tie 12/12 resolved to index 2
        mem = va;
        layer_done = 1'b0;
        clear_mon();
        pulse_start();
        check("a_busy", 64'(busy), 64'd1);
        repeat (6) tick();
        layer_done = 1'b1;
        wait_done(400, seen, cyc);
        check("a_done", 64'(seen), 64'd1);
        check("a_idx", 64'(class_idx), 64'd2);
        check("a_score", class_score, 64'd12);
        check("a_valid", 64'(result_valid), 64'd1);
        check("a_busy_end", 64'(busy), 64'd0);
        tick(); tick();
        check("a_dp_cnt", 64'(dp_cnt), 64'd1);
        check("a_ls_cnt", 64'(ls_cnt), 64'd1);
        check_addr("a_addr", 1);

        // B: all -1 -> index 0, no relaunch since layer_done stays high
        mem = vb;
        clear_mon();
        pulse_start();
        wait_done(200, seen, cyc);
        check("b_done", 64'(seen), 64'd1);
        check("b_idx", 64'(class_idx), 64'd0);
        check("b_score", class_score, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b_ls_cnt", 64'(ls_cnt), 64'd0);
        check_addr("b_addr", 0);

        // C: max -2 at index 9, most-negative present; exact latency; start during FINISH ignored
        mem = vc;
        clear_mon();
        pulse_start();
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 200 && !seen) begin
            if (done_pulse) begin
                seen = 1'b1;
            end else begin
                if (cyc == LAT_CYC - 1) start = 1'b1;
                tick();
                start = 1'b0;
                cyc++;
            end
        end
        check("c_done", 64'(seen), 64'd1);
        check("c_latency", 64'(cyc), 64'(LAT_CYC));
        check("c_idx", 64'(class_idx), 64'd9);
        check("c_score", class_score, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("c_finish_start_busy", 64'(busy), 64'd0);
        check("c_finish_start_valid", 64'(result_valid), 64'd1);
        check("c_ls_cnt", 64'(ls_cnt), 64'd0);

        // D: start in the cycle right after FINISH is accepted
        mem = va;
        clear_mon();
        pulse_start();
        wait_done(200, seen, cyc);
        check("d1_done", 64'(seen), 64'd1);
        mem = ve;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("d2_busy", 64'(busy), 64'd1);
        check("d2_valid_clr", 64'(result_valid), 64'd0);
        check("d2_idx_hold", 64'(class_idx), 64'd2);
        wait_done(200, seen, cyc);
        check("d2_done", 64'(seen), 64'd1);
        check("d2_idx", 64'(class_idx), 64'd8);
        check("d2_score", class_score, 64'd20);
        tick();
        check("d_dp_cnt", 64'(dp_cnt), 64'd2);
        check("d_ls_cnt", 64'(ls_cnt), 64'd0);

        // E: second start 5 cycles into a run is ignored
        mem = vf;
        clear_mon();
        pulse_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, seen, cyc);
        check("e_done", 64'(seen), 64'd1);
        check("e_idx", 64'(class_idx), 64'd4);
        check("e_score", class_score, 64'd9);
        repeat (60) tick();
        check("e_dp_cnt", 64'(dp_cnt), 64'd1);
        check_addr("e_addr", 0);

        // F: reset during WAIT_RD of k=4, then a clean rerun from address 0
        mem = ve;
        clear_mon();
        pulse_start();
        repeat (17) tick();
        check("f_pre_addr", 64'(rd_addr), 64'h40);
        resetn = 1'b0;
        tick();
        check_zero("f_rst");
        tick();
        resetn = 1'b1;
        mem = vg;
        clear_mon();
        pulse_start();
        wait_done(200, seen, cyc);
        check("f_done", 64'(seen), 64'd1);
        check("f_latency", 64'(cyc), 64'(LAT_CYC));
        check("f_idx", 64'(class_idx), 64'd5);
        check("f_score", class_score, 64'd11);
        check("f_ls_cnt", 64'(ls_cnt), 64'd0);
        check_addr("f_addr", 1);

        // G: layer never finishes
        layer_done = 1'b0;
        mem = va;
        clear_mon();
        pulse_start();
`ifdef LAYER_TIMEOUT_EN
        wait_done(200, seen, cyc);
        check("g_done", 64'(seen), 64'd1);
        check("g_latency", 64'(cyc), 64'd52);
        check("g_err", 64'(err), 64'd1);
        check("g_valid", 64'(result_valid), 64'd0);
        check("g_busy", 64'(busy), 64'd0);
        tick();
        check("g_err_hold", 64'(err), 64'd1);
        check("g_ls_cnt", 64'(ls_cnt), 64'd1);
        layer_done = 1'b1;
        pulse_start();
        check("g_err_clr", 64'(err), 64'd0);
        wait_done(200, seen, cyc);
        check("g_rerun_idx", 64'(class_idx), 64'd2);
`else
        repeat (100) tick();
        check("g_busy", 64'(busy), 64'd1);
        check("g_err", 64'(err), 64'd0);
        check("g_valid", 64'(result_valid), 64'd0);
        check("g_ls_cnt", 64'(ls_cnt), 64'd1);
        check("g_dp_cnt", 64'(dp_cnt), 64'd0);
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
